// File: rtl/relu_backprop.sv
// relu_backprop: records a ReLU derivative mask from the forward stream, then gates the backward gradient stream with it.
// The mask bit is set for a non-negative forward input, so zero passes the same as in the forward stage.
module relu_backprop #(
  parameter int N = 64,
  parameter int W = 16,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [W-1:0]  fwd_data,
  input  logic          fwd_valid,
  input  logic [W-1:0]  grad_in,
  input  logic          grad_in_valid,
  output logic [W-1:0]  grad_out,
  output logic          grad_out_valid,
  output logic [AW-1:0] grad_out_idx,
  output logic          mask_ready,
  output logic          err_seq
);
  typedef enum logic {CAPTURE, ARMED} state_t;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  state_t state, state_nxt;
  logic fwd_acc, grad_acc, err_hit;
  logic [AW-1:0] cidx, gidx;
  logic [N-1:0] mask;
  always_comb begin
    fwd_acc = fwd_valid && state == CAPTURE;
    grad_acc = grad_in_valid && state == ARMED;
    err_hit = (fwd_valid && state == ARMED) || (grad_in_valid && state == CAPTURE);
    state_nxt = clear ? CAPTURE :
                (fwd_acc && cidx == LAST) ? ARMED :
                (grad_acc && gidx == LAST) ? CAPTURE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= CAPTURE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cidx <= '0;
      gidx <= '0;
      mask <= '0;
      grad_out <= '0;
      grad_out_valid <= 1'b0;
      grad_out_idx <= '0;
      err_seq <= 1'b0;
    end else if (clear) begin
      cidx <= '0;
      gidx <= '0;
      grad_out_valid <= 1'b0;
      err_seq <= 1'b0;
    end else begin
      grad_out_valid <= grad_acc;
      if (fwd_acc) begin
        mask[cidx] <= $signed(fwd_data) >= $signed(W'(0));
        cidx <= cidx == LAST ? '0 : cidx + AW'(1);
      end
      if (grad_acc) begin
        grad_out <= mask[gidx] ? grad_in : '0;
        grad_out_idx <= gidx;
        gidx <= gidx == LAST ? '0 : gidx + AW'(1);
      end
      if (err_hit) err_seq <= 1'b1;
    end
  assign mask_ready = state == ARMED;
endmodule

// File: tb/tb_relu_backprop.sv
// tb_relu_backprop: reference model pushes expected gradients to a queue, negedge monitor pops and compares.
module tb_relu_backprop;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 0;
  logic reset = 0;
  logic clear = 0;
  logic [W-1:0] fwd_data = '0;
  logic fwd_valid = 0;
  logic [W-1:0] grad_in = '0;
  logic grad_in_valid = 0;
  logic [W-1:0] grad_out;
  logic grad_out_valid;
  logic [1:0] grad_out_idx;
  logic mask_ready;
  logic err_seq;
  int checks = 0;
  int failures = 0;
  typedef struct {logic [W-1:0] d; int i;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [W-1:0] log_q[$];
  logic [W-1:0] gold[4];
  bit m_armed, m_err;
  int m_c, m_g;
  logic [N-1:0] m_mask;

  relu_backprop #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .fwd_data(fwd_data), .fwd_valid(fwd_valid),
    .grad_in(grad_in), .grad_in_valid(grad_in_valid),
    .grad_out(grad_out), .grad_out_valid(grad_out_valid), .grad_out_idx(grad_out_idx),
    .mask_ready(mask_ready), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit fv, input int fd, input bit gv, input int gd, input bit cl = 0);
    @(negedge clk);
    fwd_valid = fv;
    fwd_data = fd[W-1:0];
    grad_in_valid = gv;
    grad_in = gd[W-1:0];
    clear = cl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  // Behavioural reference of the capture/armed protocol, sampled on the same edge as the DUT
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_armed = 0; m_err = 0; m_c = 0; m_g = 0; m_mask = '0;
      q.delete();
    end else if (clear) begin
      m_armed = 0; m_err = 0; m_c = 0; m_g = 0;
    end else if (!m_armed) begin
      if (grad_in_valid) m_err = 1;
      if (fwd_valid) begin
        m_mask[m_c] = !fwd_data[W-1];
        if (m_c == N - 1) begin m_c = 0; m_armed = 1; end
        else m_c++;
      end
    end else begin
      if (fwd_valid) m_err = 1;
      if (grad_in_valid) begin
        q.push_back('{m_mask[m_g] ? grad_in : '0, m_g});
        if (m_g == N - 1) begin m_g = 0; m_armed = 0; end
        else m_g++;
      end
    end
  end

  always @(negedge clk) if (reset) begin
    if (grad_out_valid) begin
      if (q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        mon_e = q.pop_front();
        check("grad_out", int'(grad_out), int'(mon_e.d));
        check("grad_out_idx", int'(grad_out_idx), mon_e.i);
      end
      log_q.push_back(grad_out);
    end
    check("mask_ready", int'(mask_ready), int'(m_armed));
    check("err_seq", int'(err_seq), int'(m_err));
  end

  initial begin
    #1;
    check("rst_grad_out", int'(grad_out), 0);
    check("rst_valid", int'(grad_out_valid), 0);
    check("rst_idx", int'(grad_out_idx), 0);
    check("rst_mask_ready", int'(mask_ready), 0);
    check("rst_err", int'(err_seq), 0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    // basic layer with the zero and most-negative corners
    cyc(1, 5, 0, 0); cyc(1, -3, 0, 0); cyc(1, 0, 0, 0); cyc(1, -32768, 0, 0);
    cyc(0, 0, 1, 100); cyc(0, 0, 1, 200); cyc(0, 0, 1, -300); cyc(0, 0, 1, 400);
    idle(2);
    gold = '{16'd100, 16'd0, 16'hFED4, 16'd0};
    check("t1_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) check("t1_gold", int'(log_q[i]), int'(gold[i]));
    // two layers with gaps; second mask all-pass
    cyc(1, -1, 0, 0); idle(1); cyc(1, 1, 0, 0); cyc(1, -1, 0, 0); idle(2); cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 1); idle(1); cyc(0, 0, 1, 2); cyc(0, 0, 1, 3); idle(1); cyc(0, 0, 1, 4);
    cyc(1, 10, 0, 0); cyc(1, 20, 0, 0); idle(1); cyc(1, 30, 0, 0); cyc(1, 40, 0, 0);
    cyc(0, 0, 1, 11); cyc(0, 0, 1, -22); cyc(0, 0, 1, 33); idle(1); cyc(0, 0, 1, -44);
    idle(2);
    check("t2_err_clean", int'(err_seq), 0);
    // gradient during capture is dropped and flags an error
    cyc(0, 0, 1, 7); idle(2);
    check("t3_err_sticky", int'(err_seq), 1);
    cyc(1, 1, 0, 0); cyc(1, -1, 0, 0); cyc(1, 1, 0, 0); cyc(1, -1, 0, 0);
    cyc(0, 0, 1, 9); cyc(0, 0, 1, 9); cyc(0, 0, 1, 9); cyc(0, 0, 1, 9);
    idle(2);
    // forward sample while armed, together with a gradient
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(1, -5, 1, 50); cyc(0, 0, 1, 60); cyc(0, 0, 1, 70); cyc(0, 0, 1, 80);
    idle(2);
    check("t4_err", int'(err_seq), 1);
    // async reset mid-layer
    cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0);
    cyc(0, 0, 1, 111); cyc(0, 0, 1, 222); idle(1);
    #2 reset = 0;
    #1;
    check("ar_grad_out", int'(grad_out), 0);
    check("ar_idx", int'(grad_out_idx), 0);
    check("ar_mask_ready", int'(mask_ready), 0);
    check("ar_err", int'(err_seq), 0);
    @(negedge clk); reset = 1;
    cyc(0, 0, 1, 3); idle(1);
    cyc(1, 4, 0, 0); cyc(1, -4, 0, 0); cyc(1, 4, 0, 0); cyc(1, -4, 0, 0);
    cyc(0, 0, 1, 5); cyc(0, 0, 1, 6); cyc(0, 0, 1, 7); cyc(0, 0, 1, 8);
    idle(2);
    // clear after a partial capture restarts the index
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(0, 0, 0, 0, 1);
    cyc(1, -1, 0, 0); cyc(1, 2, 0, 0); cyc(1, -3, 0, 0); cyc(1, 4, 0, 0);
    log_q.delete();
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 1); cyc(0, 0, 1, 1); cyc(0, 0, 1, 1);
    idle(2);
    gold = '{16'd0, 16'd1, 16'd0, 16'd1};
    check("t6_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) check("t6_gold", int'(log_q[i]), int'(gold[i]));
    check("t6_err_cleared", int'(err_seq), 0);
    check("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/relu_backprop.md
Name: relu_backprop

Overview:
- Backward-pass companion to the forward ReLU activation stage in the MNIST network datapath.
- Capture phase: records a per-neuron derivative mask from the forward activation input stream, one layer of N neurons.
- Backward phase: gates the incoming error-gradient stream with that mask. The gradient passes for neurons whose forward input was non-negative and is zeroed otherwise.
- Sits between the backward dense-layer gradient engine and the preceding layer's weight-update logic.

Parameters:
- N, 64, neurons per layer (mask depth); legal range 2..1024.
- W, 16, data width of forward and gradient samples (signed two's complement).
- AW, $clog2(N), index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; returns block to CAPTURE with index 0.
- fwd_data  input  W  signed forward activation input (pre-ReLU value).
- fwd_valid  input  1  fwd_data qualifier, one sample per cycle.
- grad_in  input  W  signed upstream gradient for neuron grad index.
- grad_in_valid  input  1  grad_in qualifier.
- grad_out  output  W  signed gated gradient.
- grad_out_valid  output  1  one-cycle pulse per accepted gradient.
- grad_out_idx  output  AW  neuron index of grad_out.
- mask_ready  output  1  high while in ARMED (full mask held).
- err_seq  output  1  sticky protocol-error flag.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to CAPTURE; capture and grad indices go to 0.
  - All mask bits go to 0.
  - grad_out=0, grad_out_valid=0, grad_out_idx=0, mask_ready=0, err_seq=0.
- Mask rule: mask[i] = ~fwd_data[W-1]. Zero counts as pass, consistent with the forward stage passing 0 through.
- State CAPTURE:
  - Each cycle with fwd_valid=1: write mask[cidx], increment cidx.
  - Accepting the sample at cidx=N-1: next state ARMED, cidx wraps to 0, mask_ready=1 from the following cycle.
  - grad_in_valid=1 in CAPTURE: sample dropped, no grad_out_valid, err_seq set.
- State ARMED:
  - Each cycle with grad_in_valid=1, registered with latency 1:
    - grad_out = mask[gidx] ? grad_in : 0.
    - grad_out_idx = gidx.
    - grad_out_valid = 1.
    - gidx increments.
  - Accepting the gradient at gidx=N-1: next state CAPTURE, gidx wraps to 0, mask_ready=0 from the following cycle.
  - fwd_valid=1 in ARMED: sample dropped, mask unchanged, err_seq set.
- grad_out_valid is 0 in every cycle with no accepted gradient. grad_out and grad_out_idx hold their last values in those cycles.
- Simultaneous fwd_valid and grad_in_valid: only the input matching the current state is accepted; the other is treated as an error drop.
- Back-to-back gradients at full rate (one per cycle) are supported with no bubbles. The transition cycle ARMED->CAPTURE accepts the last gradient; the next cycle can accept fwd_valid.
- clear=1 (synchronous, highest priority after reset):
  - State goes to CAPTURE; cidx=gidx=0; mask_ready=0; grad_out_valid=0.
  - err_seq is cleared.
  - Mask contents are not required to clear; they are overwritten by the next capture.
- err_seq remains set until reset or clear.
- No arithmetic on data: values pass unmodified or as exact zero; no saturation or width change.

Test Plan:
- N=4; fwd_data = 5, -3, 0, -32768 on consecutive cycles, then grad_in = 100, 200, -300, 400 -> grad_out = 100, 0, -300, 0 with idx 0..3, each one cycle after its input. mask_ready is high from the cycle after the 4th fwd sample to the cycle after the 4th gradient.
- Two full layers back-to-back with gaps between valids (fwd = -1,1,-1,1 then all positive) -> second pass outputs all gradients unmodified; confirms index wrap and mask overwrite. err_seq stays 0.
- grad_in_valid=1 with grad_in=7 during CAPTURE -> no grad_out_valid, err_seq=1 sticky. The subsequent layer still behaves correctly.
- In ARMED, fwd_valid=1 together with grad_in_valid=1 (grad 50, mask bit 1) -> grad_out=50 valid, mask unchanged, err_seq=1.
- Reset asserted low after 2 of 4 gradients -> all outputs 0 immediately without a clock edge. After release, 4 fwd samples are required before any grad_out_valid.
- clear pulsed after 3 fwd samples -> cidx=0. The next 4 fwd samples form the mask, verified by 4 gradients of value 1 (output 1 or 0 per sign).
